rr_arb_8: RTL



---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 35 +++
 rtl/rr_arb_8.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ      : number of requesters sharing the multiplexer
//   SEL_W      : width of the multiplexer select
//   state_e    : arbiter state (IDLE = no owner, GRANT = one owner)
//   idx2onehot : converts a select index into a one-hot grant vector
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker.
// Finds the first set bit of req_i searching upward from start_i with
// wrap-around (start_i, start_i+1, ..., 7, 0, ..., start_i-1).
// Ports:
//   req_i   [7:0] candidate requests
//   start_i [2:0] index where the search begins
//   found_o       high when any candidate bit is set
//   idx_o   [2:0] index of the chosen candidate (start_i when none)
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] start_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last
  // and wins; the 3-bit add provides the wrap-around for free.
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    cand    = start_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start_i + SEL_W'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb_8.sv
// Round-robin arbiter driving the select of an 8:1 combinational multiplexer.
// The owner keeps the grant while it requests; on release the grant moves to
// the next requester in circular order with no idle cycle in between.
// Optional feature (macro RR_ARB_HOLD_LIMIT_EN): an owner that has held the
// grant for MAX_HOLD consecutive cycles is rotated out when another requester
// is waiting; without the macro MAX_HOLD has no effect.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   req   [7:0] request per multiplexer input
//   gnt   [7:0] registered one-hot grant, zero when idle
//   sel   [2:0] registered multiplexer select, index of the gnt bit
//   busy        registered, high while a grant is active
module rr_arb_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arb_8: MAX_HOLD must be in 2..256");
  end

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] last_q, last_d;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [N_REQ-1:0] pick_req;
  logic [SEL_W-1:0] pick_start;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  // While granted, last_q equals the owner, so last_q+1 is the correct search
  // start in both states. The owner is masked out so a forced rotation cannot
  // pick the current owner again; on a normal release its bit is already 0.
  always_comb begin
    pick_req   = req;
    pick_start = last_q + SEL_W'(1);
    if (state_q == GRANT) begin
      pick_req = req & ~idx2onehot(sel_q);
    end
  end

  rr_pick8 u_pick (
    .req_i   (pick_req),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = idx2onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          last_d  = pick_idx;
`ifdef RR_ARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (pick_found) begin
            gnt_d  = idx2onehot(pick_idx);
            sel_d  = pick_idx;
            last_d = pick_idx;
`ifdef RR_ARB_HOLD_LIMIT_EN
            cnt_d  = '0;
`endif
          end else begin
            // sel intentionally keeps the last owner's index.
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            // Hold budget spent: hand over if anyone else waits,
            // otherwise keep the owner and start a fresh budget.
            cnt_d = '0;
            if (pick_found) begin
              gnt_d  = idx2onehot(pick_idx);
              sel_d  = pick_idx;
              last_d = pick_idx;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= SEL_W'(N_REQ - 1);
`ifdef RR_ARB_HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule
